// File: rtl/tetris_pkg.sv
// Shared piece definitions for the tetromino datapath: the piece encoding,
// the reserved "no piece" code and small helpers over the 7-bit bag mask.
package tetris_pkg;

  localparam int NUM_PIECES = 7;

  typedef enum logic [2:0] {
    PIECE_I = 3'd0,
    PIECE_O = 3'd1,
    PIECE_T = 3'd2,
    PIECE_S = 3'd3,
    PIECE_Z = 3'd4,
    PIECE_J = 3'd5,
    PIECE_L = 3'd6
  } piece_t;

  // Code 7 is never issued; the random source may still produce it.
  localparam logic [2:0] PIECE_NONE = 3'd7;

  // Lowest-index piece whose used bit is clear (0 if the mask is full,
  // which cannot happen because a full bag is cleared on the same edge).
  function automatic logic [2:0] lowest_unused(input logic [NUM_PIECES-1:0] used);
    logic [2:0] pick;
    pick = 3'd0;
    for (int i = NUM_PIECES - 1; i >= 0; i--) begin
      if (!used[i]) pick = 3'(i);
    end
    return pick;
  endfunction

  // Number of pieces still available in the current bag.
  function automatic logic [2:0] pieces_left(input logic [NUM_PIECES-1:0] used);
    logic [2:0] left;
    left = 3'd0;
    for (int i = 0; i < NUM_PIECES; i++) begin
      if (!used[i]) left = left + 3'd1;
    end
    return left;
  endfunction

endpackage

// File: rtl/piece_fifo.sv
// Small circular FIFO of 3-bit piece IDs. Exposes the head and the entry
// behind it so the game can show a preview without popping.
module piece_fifo
  import tetris_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [2:0]                 din,
  input  logic                       pop,
  output logic [2:0]                 head,
  output logic [2:0]                 second,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [2:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Push eligibility is judged on the count before any pop this cycle.
  always_comb begin
    do_pop  = pop && (count != '0);
    do_push = push && (count < CW'(DEPTH));
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Head and preview entries read straight out of the array.
  always_comb begin
    head   = mem[rd_ptr];
    second = mem[next_ptr(rd_ptr)];
  end

endmodule

// File: rtl/piece_bag.sv
// 7-bag piece generator: filters a raw 3-bit random stream so that every
// group of seven issued pieces is a permutation of all seven, with a
// deterministic fallback so a stuck random source still makes progress.
module piece_bag
  import tetris_pkg::*;
#(
  parameter int DEPTH     = 3,
  parameter int REJ_LIMIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] rnd,
  input  logic       en,
  input  logic       piece_req,
  output logic [2:0] piece_o,
  output logic       piece_valid,
  output logic [2:0] next_o,
  output logic       next_valid,
  output logic [2:0] bag_left
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = $clog2(REJ_LIMIT + 1);

  logic [NUM_PIECES-1:0] used;
  logic [RW-1:0]         rej_cnt;
  logic [CW-1:0]         count;
  logic [2:0]            head;
  logic [2:0]            second;

  logic                  draw;
  logic                  accept;
  logic                  fallback;
  logic                  push;
  logic [2:0]            push_id;
  logic [7:0]            used_ext;
  logic [NUM_PIECES-1:0] used_set;
  logic [NUM_PIECES-1:0] used_next;
  logic                  pop;

  // Draw decision: accept a fresh piece, or force the lowest unused one
  // once the reject run has reached its limit.
  always_comb begin
    used_ext  = {1'b1, used};
    draw      = en && (count < CW'(DEPTH));
    accept    = !used_ext[rnd];
    fallback  = draw && !accept && (rej_cnt == RW'(REJ_LIMIT - 1));
    push      = draw && (accept || fallback);
    push_id   = accept ? rnd : lowest_unused(used);
    used_set  = used | (NUM_PIECES'(1) << push_id);
    used_next = (used_set == '1) ? '0 : used_set;
    pop       = piece_req && (count != '0);
  end

  // Bag mask and reject-run counter; the counter only moves on draw cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      used    <= '0;
      rej_cnt <= '0;
    end else if (draw) begin
      if (push) begin
        used    <= used_next;
        rej_cnt <= '0;
      end else if (rej_cnt != RW'(REJ_LIMIT)) begin
        rej_cnt <= rej_cnt + RW'(1);
      end
    end
  end

  piece_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (push_id),
    .pop   (pop),
    .head  (head),
    .second(second),
    .count (count)
  );

  // Outputs are zeroed whenever the corresponding entry does not exist.
  always_comb begin
    piece_valid = (count != '0);
    next_valid  = (count >= CW'(2));
    piece_o     = piece_valid ? head : 3'd0;
    next_o      = next_valid ? second : 3'd0;
    bag_left    = pieces_left(used);
  end

endmodule

// File: tb/tb_piece_bag.sv
// Testbench for piece_bag: a table of directed vectors with hand-computed
// results, a few hand-written multi-cycle sequences, and a bag-fairness
// check driven by a 3-bit LFSR with random pops.
module tb_piece_bag;

  logic       clk;
  logic       reset;
  logic [2:0] rnd;
  logic       en;
  logic       piece_req;
  logic [2:0] piece_o;
  logic       piece_valid;
  logic [2:0] next_o;
  logic       next_valid;
  logic [2:0] bag_left;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       rst;
    logic       en;
    logic [2:0] rnd;
    logic       req;
    logic [2:0] ep;
    logic       ev;
    logic [2:0] enx;
    logic       env;
    logic [2:0] eb;
  } vec_t;

  vec_t vecs [21];

  piece_bag #(.DEPTH(3), .REJ_LIMIT(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .rnd        (rnd),
    .en         (en),
    .piece_req  (piece_req),
    .piece_o    (piece_o),
    .piece_valid(piece_valid),
    .next_o     (next_o),
    .next_valid (next_valid),
    .bag_left   (bag_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive inputs away from the edge, then return 1 ns after the edge.
  task automatic applyStimulus(input logic r, input logic e, input logic [2:0] v, input logic q);
    @(negedge clk);
    reset     = r;
    en        = e;
    rnd       = v;
    piece_req = q;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [2:0] ep, input logic ev,
                             input logic [2:0] enx, input logic env, input logic [2:0] eb);
    cmp({name, ".piece_o"},     piece_o,             ep);
    cmp({name, ".piece_valid"}, {2'b00, piece_valid}, {2'b00, ev});
    cmp({name, ".next_o"},      next_o,              enx);
    cmp({name, ".next_valid"},  {2'b00, next_valid},  {2'b00, env});
    cmp({name, ".bag_left"},    bag_left,            eb);
  endtask

  initial begin
    logic [2:0] lfsr;
    logic [6:0] seen;
    logic [2:0] popped;
    logic       req;
    int         issued;

    reset = 1'b1; en = 1'b0; rnd = 3'd0; piece_req = 1'b0;

    // rst en rnd req | piece valid next nvalid bag_left
    vecs[0]  = '{1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd7};
    vecs[1]  = '{1'b0, 1'b1, 3'd3, 1'b0, 3'd3, 1'b1, 3'd0, 1'b0, 3'd6};
    vecs[2]  = '{1'b0, 1'b1, 3'd3, 1'b0, 3'd3, 1'b1, 3'd0, 1'b0, 3'd6};
    vecs[3]  = '{1'b0, 1'b1, 3'd5, 1'b0, 3'd3, 1'b1, 3'd5, 1'b1, 3'd5};
    vecs[4]  = '{1'b0, 1'b1, 3'd7, 1'b0, 3'd3, 1'b1, 3'd5, 1'b1, 3'd5};
    vecs[5]  = '{1'b0, 1'b1, 3'd1, 1'b0, 3'd3, 1'b1, 3'd5, 1'b1, 3'd4};
    vecs[6]  = '{1'b0, 1'b1, 3'd0, 1'b0, 3'd3, 1'b1, 3'd5, 1'b1, 3'd4};
    vecs[7]  = '{1'b0, 1'b1, 3'd0, 1'b1, 3'd5, 1'b1, 3'd1, 1'b1, 3'd4};
    vecs[8]  = '{1'b0, 1'b1, 3'd0, 1'b1, 3'd1, 1'b1, 3'd0, 1'b1, 3'd3};
    vecs[9]  = '{1'b0, 1'b0, 3'd2, 1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 3'd3};
    vecs[10] = '{1'b0, 1'b0, 3'd2, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3};
    vecs[11] = '{1'b0, 1'b0, 3'd2, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3};
    vecs[12] = '{1'b0, 1'b1, 3'd1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3};
    vecs[13] = '{1'b0, 1'b1, 3'd6, 1'b0, 3'd6, 1'b1, 3'd0, 1'b0, 3'd2};
    vecs[14] = '{1'b0, 1'b1, 3'd2, 1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 3'd1};
    vecs[15] = '{1'b0, 1'b1, 3'd4, 1'b0, 3'd2, 1'b1, 3'd4, 1'b1, 3'd7};
    vecs[16] = '{1'b0, 1'b1, 3'd6, 1'b0, 3'd2, 1'b1, 3'd4, 1'b1, 3'd6};
    vecs[17] = '{1'b0, 1'b1, 3'd1, 1'b1, 3'd4, 1'b1, 3'd6, 1'b1, 3'd6};
    vecs[18] = '{1'b0, 1'b1, 3'd1, 1'b0, 3'd4, 1'b1, 3'd6, 1'b1, 3'd5};
    vecs[19] = '{1'b1, 1'b1, 3'd6, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd7};
    vecs[20] = '{1'b0, 1'b1, 3'd6, 1'b0, 3'd6, 1'b1, 3'd0, 1'b0, 3'd6};

    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].rnd, vecs[i].req);
      checkOutput($sformatf("vec%0d", i), vecs[i].ep, vecs[i].ev, vecs[i].enx, vecs[i].env, vecs[i].eb);
    end

    // Stuck rnd=7: fallback pushes 0, 1, 2 on draws 8, 16, 24; early pops ignored.
    applyStimulus(1'b1, 1'b0, 3'd7, 1'b0);
    for (int c = 1; c <= 26; c++) begin
      applyStimulus(1'b0, 1'b1, 3'd7, (c <= 5));
      checkOutput($sformatf("stuck%0d", c),
                  3'd0, (c >= 8), (c >= 16) ? 3'd1 : 3'd0, (c >= 16),
                  (c < 8) ? 3'd7 : (c < 16) ? 3'd6 : (c < 24) ? 3'd5 : 3'd4);
    end

    // rnd 0..6 with a pop every cycle once valid; bag refills on the 7th push.
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
    for (int k = 0; k < 7; k++) begin
      if (k > 0) cmp($sformatf("seq_head%0d", k), piece_o, 3'(k - 1));
      req = piece_valid;
      applyStimulus(1'b0, 1'b1, 3'(k), req);
      checkOutput($sformatf("seq%0d", k), 3'(k), 1'b1, 3'd0, 1'b0,
                  (k == 6) ? 3'd7 : 3'(6 - k));
    end
    applyStimulus(1'b0, 1'b1, 3'd0, 1'b1);
    checkOutput("newbag", 3'd0, 1'b1, 3'd0, 1'b0, 3'd6);

    // LFSR-driven fairness: every 7-piece issued group is a permutation.
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
    lfsr = 3'b001; seen = 7'h00; issued = 0;
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      reset     = 1'b0;
      en        = 1'b1;
      rnd       = lfsr;
      piece_req = 1'($urandom_range(0, 1));
      #1;
      req    = piece_req && piece_valid;
      popped = piece_o;
      @(posedge clk);
      lfsr = {lfsr[1:0], lfsr[2] ^ lfsr[1]};
      if (req) begin
        issued++;
        checks++;
        if (popped == 3'd7 || seen[popped]) begin
          failures++;
          $display("[TB] FAIL lfsr_issue%0d: got piece %0d seen mask %b", issued, popped, seen);
        end else begin
          seen = seen | (7'h01 << popped);
          if (seen == 7'h7f) seen = 7'h00;
        end
      end
    end
    checks++;
    if (issued < 100) begin
      failures++;
      $display("[TB] FAIL lfsr_progress: got %0d pops required at least 100", issued);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
